// File: rtl/camera_buffer_read_arbiter.sv
// camera_buffer_read_arbiter: round-robin burst arbiter sharing the frame-buffer read port between two requesters
// Ports: clock/reset (async, active-high), enable (low forces idle on the next edge);
//   per requester N: reqN, req_addrN, req_lenN in; grantN, rvalidN, doneN out;
//   rdata passes mem_rd_data straight through; mem_rd_en/mem_rd_addr drive the buffer read port.
module camera_buffer_read_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [4:0]            req_len0,
  output logic                  grant0,
  output logic                  rvalid0,
  output logic                  done0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [4:0]            req_len1,
  output logic                  grant1,
  output logic                  rvalid1,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);
  localparam int PW = 2 * RD_LATENCY;
  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
  state_t state, state_n;
  logic [1:0] grant_q, grant_n, own_mask;
  logic en_n, owner, owner_n, last_grant, lg_n, win;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [4:0] cnt, cnt_n, len_sel, len_eff;
  // Two-bit-per-stage shift registers carrying the owner-tagged valid and last-beat flags
  logic [PW-1:0] rv_q, rv_n, dn_q, dn_n;
  assign win = (req0 & req1) ? ~last_grant : req1;
  assign len_sel = win ? req_len1 : req_len0;
  assign len_eff = (len_sel == 5'd0) ? 5'd1 : (len_sel > 5'(MAX_BURST)) ? 5'(MAX_BURST) : len_sel;
  assign own_mask = owner ? 2'b10 : 2'b01;
  assign {grant1, grant0} = grant_q;
  assign {rvalid1, rvalid0} = rv_q[PW-1 -: 2];
  assign {done1, done0} = dn_q[PW-1 -: 2];
  assign rdata = mem_rd_data;
  always_comb begin
    state_n = state;
    grant_n = 2'b00;
    en_n = mem_rd_en;
    addr_n = mem_rd_addr;
    cnt_n = cnt;
    owner_n = owner;
    lg_n = last_grant;
    rv_n = (rv_q << 2) | PW'(mem_rd_en ? own_mask : 2'b00);
    dn_n = (dn_q << 2) | PW'((mem_rd_en && cnt == 5'd1) ? own_mask : 2'b00);
    case (state)
      IDLE: if (req0 | req1) begin
        state_n = BURST;
        grant_n = win ? 2'b10 : 2'b01;
        en_n = 1'b1;
        addr_n = win ? req_addr1 : req_addr0;
        cnt_n = len_eff;
        owner_n = win;
        lg_n = win;
      end
      BURST: if (cnt == 5'd1) begin
        state_n = DRAIN;
        en_n = 1'b0;
      end else begin
        addr_n = mem_rd_addr + ADDR_WIDTH'(1);
        cnt_n = cnt - 5'd1;
      end
      // The final beat's done leaves the pipeline this cycle, so it is empty afterwards
      DRAIN: state_n = |dn_q[PW-1 -: 2] ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
    if (!enable) begin
      state_n = IDLE;
      grant_n = 2'b00;
      en_n = 1'b0;
      addr_n = '0;
      cnt_n = 5'd0;
      owner_n = 1'b0;
      lg_n = 1'b1;
      rv_n = '0;
      dn_n = '0;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant_q <= 2'b00;
      mem_rd_en <= 1'b0;
      mem_rd_addr <= '0;
      cnt <= 5'd0;
      owner <= 1'b0;
      last_grant <= 1'b1;
      rv_q <= '0;
      dn_q <= '0;
    end else begin
      state <= state_n;
      grant_q <= grant_n;
      mem_rd_en <= en_n;
      mem_rd_addr <= addr_n;
      cnt <= cnt_n;
      owner <= owner_n;
      last_grant <= lg_n;
      rv_q <= rv_n;
      dn_q <= dn_n;
    end
  end
endmodule

// File: tb/tb_camera_buffer_read_arbiter.sv
// tb_camera_buffer_read_arbiter: directed self-checking bench for camera_buffer_read_arbiter
module tb_camera_buffer_read_arbiter;
  logic clock = 1'b0, reset = 1'b1, enable = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, grant0, grant1, rvalid0, rvalid1, done0, done1, mem_rd_en;
  logic [15:0] req_addr0 = '0, req_addr1 = '0, mem_rd_addr;
  logic [4:0] req_len0 = '0, req_len1 = '0;
  logic [31:0] rdata, mem_rd_data = '0;
  logic req0_b = 1'b0, req1_b = 1'b0, grant0_b, grant1_b, rvalid0_b, rvalid1_b, done0_b, done1_b, mem_rd_en_b;
  logic [15:0] mem_rd_addr_b;
  logic [31:0] rdata_b, mem_rd_data_b = '0, d1 = '0, d2 = '0;
  int checks = 0, errors = 0;
  camera_buffer_read_arbiter dut (
    .clock(clock), .reset(reset), .enable(enable),
    .req0(req0), .req_addr0(req_addr0), .req_len0(req_len0), .grant0(grant0), .rvalid0(rvalid0), .done0(done0),
    .req1(req1), .req_addr1(req_addr1), .req_len1(req_len1), .grant1(grant1), .rvalid1(rvalid1), .done1(done1),
    .rdata(rdata), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );
  camera_buffer_read_arbiter #(.RD_LATENCY(3)) dut_b (
    .clock(clock), .reset(reset), .enable(enable),
    .req0(req0_b), .req_addr0(16'h0040), .req_len0(5'd3), .grant0(grant0_b), .rvalid0(rvalid0_b), .done0(done0_b),
    .req1(req1_b), .req_addr1(16'h0000), .req_len1(5'd0), .grant1(grant1_b), .rvalid1(rvalid1_b), .done1(done1_b),
    .rdata(rdata_b), .mem_rd_en(mem_rd_en_b), .mem_rd_addr(mem_rd_addr_b), .mem_rd_data(mem_rd_data_b)
  );
  always #5 clock = ~clock;
  always @(posedge clock) mem_rd_data <= {~mem_rd_addr, mem_rd_addr};
  always @(posedge clock) begin
    d1 <= {~mem_rd_addr_b, mem_rd_addr_b};
    d2 <= d1;
    mem_rd_data_b <= d2;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic burst(input int who, input logic [15:0] a, input int n);
    logic [1:0] m;
    m = who ? 2'b10 : 2'b01;
    for (int c = 1; c <= n + 2; c++) begin
      @(posedge clock); #1;
      check("grant", {grant1, grant0}, c == 1 ? m : 2'b00);
      check("rd_en", mem_rd_en, c <= n);
      if (c <= n) check("rd_addr", mem_rd_addr, 16'(a + c - 1));
      check("rvalid", {rvalid1, rvalid0}, (c >= 2 && c <= n + 1) ? m : 2'b00);
      check("done", {done1, done0}, c == n + 1 ? m : 2'b00);
      if (c >= 2 && c <= n + 1) check("rdata", rdata, {~16'(a + c - 2), 16'(a + c - 2)});
    end
  endtask
  task automatic idle_outputs(input string tag);
    check(tag, {grant1, grant0, rvalid1, rvalid0, done1, done0, mem_rd_en}, 0);
    check({tag, "_addr"}, mem_rd_addr, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    req0 = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    idle_outputs("reset");
    req0 = 1'b0;
    reset = 1'b0;
    req_addr0 = 16'h0010; req_len0 = 5'd4; req0 = 1'b1;
    burst(0, 16'h0010, 4);
    req0 = 1'b0;
    reset = 1'b1; #1; reset = 1'b0;
    req_addr0 = 16'h0100; req_addr1 = 16'h0200; req_len0 = 5'd2; req_len1 = 5'd2;
    req0 = 1'b1; req1 = 1'b1;
    burst(0, 16'h0100, 2);
    burst(1, 16'h0200, 2);
    burst(0, 16'h0100, 2);
    burst(1, 16'h0200, 2);
    req0 = 1'b0; req1 = 1'b0;
    req_addr0 = 16'h0020; req_len0 = 5'd0; req0 = 1'b1;
    burst(0, 16'h0020, 1);
    req_len0 = 5'd16;
    burst(0, 16'h0020, 16);
    req_len0 = 5'd31;
    burst(0, 16'h0020, 16);
    req0 = 1'b0;
    req_addr1 = 16'hFFFE; req_len1 = 5'd4; req1 = 1'b1;
    burst(1, 16'hFFFE, 4);
    req1 = 1'b0;
    req_addr0 = 16'h0300; req_len0 = 5'd8; req0 = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("en_mid_burst", mem_rd_en, 1);
    enable = 1'b0;
    @(posedge clock); #1;
    idle_outputs("enable_low");
    enable = 1'b1; req0 = 1'b0;
    req_addr0 = 16'h0310; req_addr1 = 16'h0320; req_len0 = 5'd1; req_len1 = 5'd1;
    req0 = 1'b1; req1 = 1'b1;
    burst(0, 16'h0310, 1);
    req0 = 1'b0; req1 = 1'b0;
    req_addr0 = 16'h0400; req_len0 = 5'd8; req0 = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("abort_beat2_addr", mem_rd_addr, 16'h0401);
    check("abort_beat2_rvalid", rvalid0, 1);
    #2 reset = 1'b1;
    #1;
    idle_outputs("abort");
    reset = 1'b0;
    req_addr0 = 16'h0500; req_addr1 = 16'h0600; req_len0 = 5'd2; req_len1 = 5'd2;
    req0 = 1'b1; req1 = 1'b1;
    burst(0, 16'h0500, 2);
    req0 = 1'b0; req1 = 1'b0;
    req0_b = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock); #1;
      check("lat3_grant", {grant1_b, grant0_b}, (c == 1 || c == 8) ? 2'b01 : 2'b00);
      check("lat3_rd_en", mem_rd_en_b, c <= 3 || c == 8);
      if (c <= 3) check("lat3_rd_addr", mem_rd_addr_b, 16'(16'h0040 + c - 1));
      check("lat3_rvalid", {rvalid1_b, rvalid0_b}, (c >= 4 && c <= 6) ? 2'b01 : 2'b00);
      check("lat3_done", {done1_b, done0_b}, c == 6 ? 2'b01 : 2'b00);
      if (c >= 4 && c <= 6) check("lat3_rdata", rdata_b, {~16'(16'h0040 + c - 4), 16'(16'h0040 + c - 4)});
    end
    req0_b = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
